// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the Wishbone slave multiplexer.
package wb_mux_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [1:0] ERR_MISS    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned N_SLV_DEF  = 5;
  localparam int unsigned TO_CYC_DEF = 255;

  localparam logic [N_SLV_DEF*32-1:0] SLV_BASE_DEF = {
    32'h3800_0000, 32'h3000_0000, 32'h3000_0300, 32'h3000_0200, 32'h3000_0100
  };
  localparam logic [N_SLV_DEF*32-1:0] SLV_MASK_DEF = {
    32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0F00, 32'hFF00_0F00, 32'hFF00_0F00
  };

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned TO_CNT_W_DEF = clog2_min1(TO_CYC_DEF);

endpackage

// File: rtl/wb_addr_match.sv
// Priority address decoder: lowest-index slave whose masked base matches wins.
module wb_addr_match
  import wb_mux_pkg::*;
#(
  parameter int unsigned              N_SLV    = N_SLV_DEF,
  parameter logic [N_SLV*32-1:0]      SLV_BASE = SLV_BASE_DEF,
  parameter logic [N_SLV*32-1:0]      SLV_MASK = SLV_MASK_DEF,
  parameter int unsigned              IDX_W    = clog2_min1(N_SLV)
) (
  input  logic [31:0]      i_adr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if ((i_adr & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_slave_mux.sv
// Wishbone slave-side multiplexer: decodes one master request onto N_SLV slaves,
// with a bus timeout and a sticky error log.
module wb_slave_mux
  import wb_mux_pkg::*;
#(
  parameter int unsigned         N_SLV    = N_SLV_DEF,
  parameter logic [N_SLV*32-1:0] SLV_BASE = SLV_BASE_DEF,
  parameter logic [N_SLV*32-1:0] SLV_MASK = SLV_MASK_DEF,
  parameter int unsigned         TO_CYC   = TO_CYC_DEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic                wbs_err_o,
  output logic [31:0]         wbs_dat_o,
  output logic [N_SLV-1:0]    slv_valid_o,
  output logic                slv_we_o,
  output logic [3:0]          slv_sel_o,
  output logic [31:0]         slv_dat_o,
  output logic [31:0]         slv_adr_o,
  input  logic [N_SLV-1:0]    slv_ack_i,
  input  logic [N_SLV*32-1:0] slv_dat_i,
  output logic [15:0]         err_cnt_o,
  output logic [1:0]          err_type_o,
  output logic [31:0]         err_adr_o
);

  localparam int unsigned     IdxW    = clog2_min1(N_SLV);
  localparam int unsigned     CntW    = clog2_min1(TO_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TO_CYC - 1);

  state_e            r_state, w_state_d;
  logic              w_hit;
  logic [IdxW-1:0]   w_idx;
  logic [IdxW-1:0]   r_idx;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdat;
  logic [31:0]       r_adr;
  logic [31:0]       r_rdat;
  logic              r_err_pend;
  logic [CntW-1:0]   r_cnt;
  logic              w_req;
  logic              w_ack_sel;
  logic              w_timeout;
  logic              w_log_miss;
  logic              w_log_to;
  logic [15:0]       r_err_cnt, w_err_cnt_d;
  logic [1:0]        r_err_type, w_err_type_d;
  logic [31:0]       r_err_adr, w_err_adr_d;

  wb_addr_match #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .IDX_W    (IdxW)
  ) u_addr_match (
    .i_adr (wbs_adr_i),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  assign w_req     = wbs_cyc_i & wbs_stb_i;
  assign w_ack_sel = slv_ack_i[r_idx];
  assign w_timeout = (r_cnt == CntLast);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_req) w_state_d = w_hit ? StBusy : StResp;
      // A master abort outranks both the slave ack and the timeout.
      StBusy: begin
        if (!wbs_cyc_i)                  w_state_d = StIdle;
        else if (w_ack_sel || w_timeout) w_state_d = StResp;
      end
      StResp: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    wbs_ack_o   = 1'b0;
    wbs_err_o   = 1'b0;
    wbs_dat_o   = '0;
    slv_valid_o = '0;
    unique case (r_state)
      StBusy: slv_valid_o[r_idx] = 1'b1;
      StResp: begin
        wbs_ack_o = ~r_err_pend;
        wbs_err_o = r_err_pend;
        if (!r_err_pend && !r_we) wbs_dat_o = r_rdat;
      end
      default: ;
    endcase
  end

  assign slv_we_o  = r_we;
  assign slv_sel_o = r_sel;
  assign slv_dat_o = r_wdat;
  assign slv_adr_o = r_adr;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_wdat     <= '0;
      r_adr      <= '0;
      r_rdat     <= '0;
      r_err_pend <= 1'b0;
      r_cnt      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_req) begin
            r_idx      <= w_idx;
            r_we       <= wbs_we_i;
            r_sel      <= wbs_sel_i;
            r_wdat     <= wbs_dat_i;
            r_adr      <= wbs_adr_i;
            r_err_pend <= ~w_hit;
          end
        end
        StBusy: begin
          if (!wbs_cyc_i) begin
            r_cnt <= '0;
          end else if (w_ack_sel) begin
            r_rdat     <= slv_dat_i[r_idx*32 +: 32];
            r_err_pend <= 1'b0;
            r_cnt      <= '0;
          end else if (w_timeout) begin
            r_err_pend <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign w_log_miss = (r_state == StIdle) && w_req && !w_hit;
  assign w_log_to   = (r_state == StBusy) && wbs_cyc_i && !w_ack_sel && w_timeout;

  always_comb begin
    w_err_cnt_d  = r_err_cnt;
    w_err_type_d = r_err_type;
    w_err_adr_d  = r_err_adr;
    if (w_log_miss || w_log_to) begin
      w_err_cnt_d  = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
      w_err_type_d = w_log_miss ? ERR_MISS : ERR_TIMEOUT;
      w_err_adr_d  = w_log_miss ? wbs_adr_i : r_adr;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_err_cnt  <= '0;
      r_err_type <= '0;
      r_err_adr  <= '0;
    end else begin
      r_err_cnt  <= w_err_cnt_d;
      r_err_type <= w_err_type_d;
      r_err_adr  <= w_err_adr_d;
    end
  end

  assign err_cnt_o  = r_err_cnt;
  assign err_type_o = r_err_type;
  assign err_adr_o  = r_err_adr;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux with TO_CYC=8 and the default address map.
module tb_wb_slave_mux;

  localparam int unsigned NS = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     wdat, adr;
  logic            ack, err;
  logic [31:0]     rdat;
  logic [NS-1:0]   slv_valid;
  logic            slv_we;
  logic [3:0]      slv_sel;
  logic [31:0]     slv_dat, slv_adr;
  logic [NS-1:0]   slv_ack;
  logic [NS*32-1:0] slv_rdat;
  logic [15:0]     err_cnt;
  logic [1:0]      err_type;
  logic [31:0]     err_adr;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  wb_slave_mux #(
    .TO_CYC (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (wdat),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_err_o   (err),
    .wbs_dat_o   (rdat),
    .slv_valid_o (slv_valid),
    .slv_we_o    (slv_we),
    .slv_sel_o   (slv_sel),
    .slv_dat_o   (slv_dat),
    .slv_adr_o   (slv_adr),
    .slv_ack_i   (slv_ack),
    .slv_dat_i   (slv_rdat),
    .err_cnt_o   (err_cnt),
    .err_type_o  (err_type),
    .err_adr_o   (err_adr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [3:0] s,
                     input logic [31:0] d);
    cyc  = 1'b1;
    stb  = 1'b1;
    adr  = a;
    we   = w;
    sel  = s;
    wdat = d;
  endtask

  task automatic bus_idle();
    cyc = 1'b0;
    stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; wdat = '0; adr = '0;
    slv_ack  = '0;
    slv_rdat = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    step();
    step();
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_valid", slv_valid, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_slv_adr", slv_adr, 0);
    rst = 1'b0;
    step();

    // Read hitting slaves 0 and 3: slave 0 wins; slave 1 ack must be ignored.
    req(32'h3000_0104, 1'b0, 4'hF, 32'h0);
    step();
    check("rd_valid_t1", slv_valid, 5'b00001);
    check("rd_slv_adr", slv_adr, 32'h3000_0104);
    check("rd_slv_we", slv_we, 0);
    check("rd_ack_t1", ack, 0);
    step();
    check("rd_valid_t2", slv_valid, 5'b00001);
    slv_ack = 5'b00010;
    step();
    check("rd_valid_t3", slv_valid, 5'b00001);
    check("rd_ack_t3", ack, 0);
    slv_ack = 5'b00001;
    step();
    check("rd_ack_t4", ack, 1);
    check("rd_dat_t4", rdat, 32'hDEAD_BEEF);
    check("rd_valid_t4", slv_valid, 0);
    check("rd_err_t4", err, 0);
    slv_ack = '0;
    bus_idle();
    step();
    check("rd_ack_t5", ack, 0);
    check("rd_dat_t5", rdat, 0);

    // Write to slave 3.
    req(32'h3000_0010, 1'b1, 4'b0011, 32'hCAFE_0001);
    step();
    check("wr_valid_t1", slv_valid, 5'b01000);
    check("wr_slv_we", slv_we, 1);
    check("wr_slv_sel", slv_sel, 4'b0011);
    check("wr_slv_dat", slv_dat, 32'hCAFE_0001);
    slv_ack = 5'b01000;
    step();
    check("wr_ack_t2", ack, 1);
    check("wr_dat_t2", rdat, 0);
    slv_ack = '0;
    bus_idle();
    step();
    check("wr_ack_t3", ack, 0);

    // Decode miss.
    req(32'h2000_0000, 1'b0, 4'hF, 32'h0);
    step();
    check("miss_err_t1", err, 1);
    check("miss_ack_t1", ack, 0);
    check("miss_valid_t1", slv_valid, 0);
    check("miss_cnt", err_cnt, 1);
    check("miss_type", err_type, 2'b01);
    check("miss_adr", err_adr, 32'h2000_0000);
    bus_idle();
    step();
    check("miss_err_t2", err, 0);

    // Timeout on slave 4 with no ack: 8 BUSY cycles, then error.
    req(32'h3800_0000, 1'b0, 4'hF, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("to_valid_t%0d", i), slv_valid, 5'b10000);
      check($sformatf("to_err_t%0d", i), err, 0);
    end
    step();
    check("to_err_t9", err, 1);
    check("to_valid_t9", slv_valid, 0);
    check("to_type", err_type, 2'b10);
    check("to_cnt", err_cnt, 2);
    check("to_adr", err_adr, 32'h3800_0000);
    bus_idle();
    step();
    check("to_err_t10", err, 0);

    // Master abort mid-BUSY.
    req(32'h3000_0200, 1'b0, 4'hF, 32'h0);
    step();
    check("ab_valid_t1", slv_valid, 5'b00010);
    step();
    check("ab_valid_t2", slv_valid, 5'b00010);
    bus_idle();
    step();
    check("ab_valid_t3", slv_valid, 0);
    check("ab_ack_t3", ack, 0);
    check("ab_err_t3", err, 0);
    step();
    check("ab_ack_t4", ack, 0);
    check("ab_err_t4", err, 0);
    check("ab_cnt", err_cnt, 2);

    // Reset mid-BUSY with the selected slave acking during reset.
    req(32'h3000_0300, 1'b0, 4'hF, 32'h0);
    step();
    check("rb_valid_t1", slv_valid, 5'b00100);
    rst     = 1'b1;
    slv_ack = 5'b00100;
    step();
    check("rb_valid", slv_valid, 0);
    check("rb_ack", ack, 0);
    check("rb_err", err, 0);
    check("rb_err_cnt", err_cnt, 0);
    check("rb_err_adr", err_adr, 0);
    check("rb_slv_adr", slv_adr, 0);
    step();
    rst = 1'b0;
    bus_idle();
    step();
    check("rb_ack_after", ack, 0);
    check("rb_valid_after", slv_valid, 0);
    slv_ack = '0;
    step();

    // Back-to-back misses with stb held, then saturation of the error count.
    req(32'h2000_0004, 1'b0, 4'hF, 32'h0);
    step();
    check("bb_err_t1", err, 1);
    check("bb_cnt_t1", err_cnt, 1);
    step();
    check("bb_err_t2", err, 0);
    step();
    check("bb_err_t3", err, 1);
    check("bb_cnt_t3", err_cnt, 2);
    bus_idle();
    step();
    force dut.r_err_cnt = 16'hFFFD;
    step();
    step();
    release dut.r_err_cnt;
    step();
    req(32'h2000_0008, 1'b0, 4'hF, 32'h0);
    step();
    check("sat_cnt_1", err_cnt, 16'hFFFE);
    step();
    step();
    check("sat_cnt_2", err_cnt, 16'hFFFF);
    step();
    step();
    check("sat_cnt_3", err_cnt, 16'hFFFF);
    check("sat_err", err, 1);
    check("sat_adr", err_adr, 32'h2000_0008);
    bus_idle();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
